// File: rtl/fp_mon_pkg.sv
// Shared definitions for the floating-point status-flag monitor: rule indices,
// monitor state encoding and IEEE-style exponent/mantissa classifiers.
package fp_mon_pkg;

    localparam int NUM_RULES      = 14;
    localparam int RULE_ZERO_INF  = 0;
    localparam int RULE_ZERO_NAN  = 1;
    localparam int RULE_ZERO_HUGE = 2;
    localparam int RULE_INF_NAN   = 3;
    localparam int RULE_INF_TINY  = 4;
    localparam int RULE_NAN_TINY  = 5;
    localparam int RULE_NAN_HUGE  = 6;
    localparam int RULE_TINY_HUGE = 7;
    localparam int RULE_ZERO_EXP  = 8;
    localparam int RULE_INF_EXP   = 9;
    localparam int RULE_NAN_SRC   = 10;
    localparam int RULE_HUGE_EXP  = 11;
    localparam int RULE_TINY_EXP  = 12;
    localparam int RULE_LAT       = 13;

    // Classifier inputs are zero-extended to this width; field widths are passed in.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_TRIPPED  = 2'b10
    } mon_state_e;

    function automatic logic [MAX_W-1:0] ones(input int w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    function automatic logic is_exp0(input logic [MAX_W-1:0] e);
        return e == '0;
    endfunction

    function automatic logic is_exp1(input logic [MAX_W-1:0] e, input int exp_w);
        return e == ones(exp_w);
    endfunction

    function automatic logic is_max_norm(input logic [MAX_W-1:0] e, input logic [MAX_W-1:0] m,
                                         input int exp_w, input int man_w);
        return (e == ones(exp_w) - MAX_W'(1)) && (m == ones(man_w));
    endfunction

    function automatic logic is_min_norm(input logic [MAX_W-1:0] e, input logic [MAX_W-1:0] m);
        return (e == MAX_W'(1)) && (m == '0);
    endfunction

endpackage

// File: rtl/fp_mon_delay_line.sv
// Re-times operand exponents to line up with the multiplier output beat.
// Only the valid tags are reset; exponent payload is qualified by them.
module fp_mon_delay_line #(
    parameter int LATENCY = 3,
    parameter int EXP_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    output logic             d_valid,
    output logic [EXP_W-1:0] d_aexp,
    output logic [EXP_W-1:0] d_bexp
);

    logic [LATENCY-1:0] v_q;
    logic [EXP_W-1:0]   a_q [LATENCY];
    logic [EXP_W-1:0]   b_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) v_q[i] <= v_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        a_q[0] <= a_exp;
        b_q[0] <= b_exp;
        for (int i = 1; i < LATENCY; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
        end
    end

    assign d_valid = v_q[LATENCY-1];
    assign d_aexp  = a_q[LATENCY-1];
    assign d_bexp  = b_q[LATENCY-1];

endmodule

// File: rtl/fp_status_monitor.sv
// Checks floating-point multiplier status flags against result/operand encodings
// on every output beat; keeps sticky failures, a saturating count and a first-failure capture.
module fp_status_monitor
    import fp_mon_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16,
    parameter int W       = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             out_valid,
    input  logic [W-1:0]     z,
    input  logic             zero_f,
    input  logic             inf_f,
    input  logic             nan_f,
    input  logic             tiny_f,
    input  logic             huge_f,
    output logic [13:0]      chk_fail,
    output logic [13:0]      sticky_fail,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       first_idx,
    output logic [CNT_W-1:0] first_time,
    output logic [1:0]       state
);

    logic             d_valid;
    logic [EXP_W-1:0] d_aexp;
    logic [EXP_W-1:0] d_bexp;
    logic [MAX_W-1:0] z_exp;
    logic [MAX_W-1:0] z_man;
    logic [MAX_W-1:0] da_exp;
    logic [MAX_W-1:0] db_exp;
    logic [13:0]      rule;
    logic             any_fail;
    logic             capture;
    logic [CNT_W-1:0] cyc_cnt;
    mon_state_e       state_q;
    mon_state_e       state_d;

    fp_mon_delay_line #(
        .LATENCY (LATENCY),
        .EXP_W   (EXP_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a_exp    (a[MAN_W +: EXP_W]),
        .b_exp    (b[MAN_W +: EXP_W]),
        .d_valid  (d_valid),
        .d_aexp   (d_aexp),
        .d_bexp   (d_bexp)
    );

    assign z_exp  = MAX_W'(z[MAN_W +: EXP_W]);
    assign z_man  = MAX_W'(z[MAN_W-1:0]);
    assign da_exp = MAX_W'(d_aexp);
    assign db_exp = MAX_W'(d_bexp);

    function automatic logic [3:0] lowest_idx(input logic [13:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_comb begin
        rule = '0;
        if (out_valid && enable) begin
            rule[RULE_ZERO_INF]  = zero_f & inf_f;
            rule[RULE_ZERO_NAN]  = zero_f & nan_f;
            rule[RULE_ZERO_HUGE] = zero_f & huge_f;
            rule[RULE_INF_NAN]   = inf_f  & nan_f;
            rule[RULE_INF_TINY]  = inf_f  & tiny_f;
            rule[RULE_NAN_TINY]  = nan_f  & tiny_f;
            rule[RULE_NAN_HUGE]  = nan_f  & huge_f;
            rule[RULE_TINY_HUGE] = tiny_f & huge_f;
            rule[RULE_ZERO_EXP]  = zero_f & !is_exp0(z_exp);
            rule[RULE_INF_EXP]   = inf_f  & !is_exp1(z_exp, EXP_W);
            // A NaN result is only legal from 0 x inf in either operand order.
            rule[RULE_NAN_SRC]   = nan_f & d_valid &
                                   !((is_exp0(da_exp) && is_exp1(db_exp, EXP_W)) ||
                                     (is_exp0(db_exp) && is_exp1(da_exp, EXP_W)));
            rule[RULE_HUGE_EXP]  = huge_f & !(is_exp1(z_exp, EXP_W) ||
                                              is_max_norm(z_exp, z_man, EXP_W, MAN_W));
            rule[RULE_TINY_EXP]  = tiny_f & !(is_exp0(z_exp) || is_min_norm(z_exp, z_man));
            rule[RULE_LAT]       = !d_valid;
        end
    end

    assign any_fail = |rule;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_DISABLED;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED:    if (!clear && any_fail) state_d = ST_TRIPPED;
                ST_TRIPPED:  if (clear) state_d = ST_ARMED;
                default:     state_d = ST_DISABLED;
            endcase
        end
    end

    // Output logic: the capture only fires on the arming-to-tripped transition.
    always_comb begin
        capture = 1'b0;
        if (state_q == ST_ARMED && enable && any_fail && !clear) capture = 1'b1;
    end

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_fail    <= '0;
            sticky_fail <= '0;
            fail_cnt    <= '0;
            first_idx   <= '0;
            first_time  <= '0;
            cyc_cnt     <= '0;
        end else begin
            chk_fail <= rule;
            if (enable) cyc_cnt <= cyc_cnt + CNT_W'(1);
            // clear beats a same-cycle failure everywhere except chk_fail.
            if (clear) begin
                sticky_fail <= '0;
                fail_cnt    <= '0;
                first_idx   <= '0;
                first_time  <= '0;
            end else begin
                sticky_fail <= sticky_fail | rule;
                if (any_fail && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                if (capture) begin
                    first_idx  <= lowest_idx(rule);
                    first_time <= cyc_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_status_monitor.sv
// Directed bench for fp_status_monitor with FP32 parameters and hand-computed expectations.
module tb_fp_status_monitor;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid = 1'b0;
    logic [31:0] z = '0;
    logic        zero_f = 1'b0, inf_f = 1'b0, nan_f = 1'b0, tiny_f = 1'b0, huge_f = 1'b0;
    logic [13:0] chk_fail, sticky_fail;
    logic [15:0] fail_cnt, first_time;
    logic [3:0]  first_idx;
    logic [1:0]  state;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cyc = '0;
    logic [15:0] rec_time = '0;

    always #5 clk = ~clk;

    fp_status_monitor #(
        .EXP_W(8), .MAN_W(23), .LATENCY(LAT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .z(z),
        .zero_f(zero_f), .inf_f(inf_f), .nan_f(nan_f), .tiny_f(tiny_f), .huge_f(huge_f),
        .chk_fail(chk_fail), .sticky_fail(sticky_fail), .fail_cnt(fail_cnt),
        .first_idx(first_idx), .first_time(first_time), .state(state)
    );

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (enable && !rst) exp_cyc = exp_cyc + 16'd1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_flags(input logic [4:0] f);
        {zero_f, inf_f, nan_f, tiny_f, huge_f} = f;
    endtask

    // Operands at t0, result beat at t0+LAT; returns after the registered cycle.
    task automatic beat(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tz,
                        input logic [4:0] f);
        in_valid = 1'b1; a = ta; b = tb_;
        step();
        in_valid = 1'b0;
        repeat (LAT - 1) step();
        out_valid = 1'b1; z = tz; set_flags(f);
        rec_time = exp_cyc;
        step();
        out_valid = 1'b0; set_flags(5'b0);
    endtask

    // flag vector order: {zero, inf, nan, tiny, huge}
    initial begin
        #1;
        step();
        step();
        check("rst_chk", 32'(chk_fail), 0);
        check("rst_sticky", 32'(sticky_fail), 0);
        check("rst_cnt", 32'(fail_cnt), 0);
        check("rst_first_idx", 32'(first_idx), 0);
        check("rst_first_time", 32'(first_time), 0);
        check("rst_state", 32'(state), 0);

        rst = 1'b0; enable = 1'b1;
        step();
        check("armed_state", 32'(state), 1);

        beat(32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b00100);
        check("nan_ok_chk", 32'(chk_fail), 0);
        check("nan_ok_state", 32'(state), 1);

        beat(32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b00100);
        check("nan_bad_chk", 32'(chk_fail), 32'h400);
        check("nan_bad_idx", 32'(first_idx), 10);
        check("nan_bad_time", 32'(first_time), 32'(rec_time));
        check("nan_bad_state", 32'(state), 2);
        check("nan_bad_cnt", 32'(fail_cnt), 1);
        check("nan_bad_sticky", 32'(sticky_fail), 32'h400);
        step();
        check("idle_chk", 32'(chk_fail), 0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_state", 32'(state), 1);
        check("clr_sticky", 32'(sticky_fail), 0);
        check("clr_cnt", 32'(fail_cnt), 0);

        beat(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 5'b11000);
        check("zinf_chk", 32'(chk_fail), 32'h201);
        check("zinf_idx", 32'(first_idx), 0);
        check("zinf_time", 32'(first_time), 32'(rec_time));
        check("zinf_state", 32'(state), 2);

        beat(32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 5'b00001);
        check("huge_max_chk", 32'(chk_fail), 0);
        beat(32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFE, 5'b00001);
        check("huge_bad_chk", 32'(chk_fail), 32'h800);
        beat(32'h3F80_0000, 32'h3F80_0000, 32'h0080_0000, 5'b00010);
        check("tiny_min_chk", 32'(chk_fail), 0);
        beat(32'h3F80_0000, 32'h3F80_0000, 32'h0080_0001, 5'b00010);
        check("tiny_bad_chk", 32'(chk_fail), 32'h1000);
        check("accum_sticky", 32'(sticky_fail), 32'h1A01);
        check("accum_cnt", 32'(fail_cnt), 3);
        check("accum_idx", 32'(first_idx), 0);

        enable = 1'b0;
        out_valid = 1'b1; set_flags(5'b11000);
        step();
        out_valid = 1'b0; set_flags(5'b0);
        check("dis_state", 32'(state), 0);
        check("dis_chk", 32'(chk_fail), 0);
        check("dis_sticky", 32'(sticky_fail), 32'h1A01);
        check("dis_cnt", 32'(fail_cnt), 3);
        enable = 1'b1;
        step();
        check("reen_state", 32'(state), 1);

        rst = 1'b1; enable = 1'b0; exp_cyc = '0;
        #1;
        check("rst2_sticky", 32'(sticky_fail), 0);
        check("rst2_state", 32'(state), 0);
        step();
        rst = 1'b0; enable = 1'b1;
        step();
        out_valid = 1'b1; z = 32'h3F80_0000;
        rec_time = exp_cyc;
        step();
        check("lat_chk", 32'(chk_fail), 32'h2000);
        check("lat_idx", 32'(first_idx), 13);
        check("lat_time", 32'(first_time), 32'(rec_time));
        check("lat_state", 32'(state), 2);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clrfail_chk", 32'(chk_fail), 32'h2000);
        check("clrfail_sticky", 32'(sticky_fail), 0);
        check("clrfail_cnt", 32'(fail_cnt), 0);
        check("clrfail_state", 32'(state), 1);

        rec_time = exp_cyc;
        repeat (65536 + 5) step();
        out_valid = 1'b0;
        check("sat_cnt", 32'(fail_cnt), 32'hFFFF);
        check("sat_sticky", 32'(sticky_fail), 32'h2000);
        check("sat_idx", 32'(first_idx), 13);
        check("sat_time", 32'(first_time), 32'(rec_time));
        check("sat_state", 32'(state), 2);
        step();
        check("sat_hold_cnt", 32'(fail_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
